// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared legality limits for the pipelined carry-lookahead adder/subtractor.
package pipelined_cla_addsub_pkg;
    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned MIN_BLOCK = 2;
    localparam int unsigned MAX_BLOCK = 16;
endpackage

// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle between the producer, the adder and the consumer.
interface pipelined_cla_addsub_if #(parameter int unsigned WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_cla_addsub_block.sv
// One lookahead block: conditional sums for carry-in 0/1 plus block generate/propagate.
module cla_block_n #(
    parameter int unsigned BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    output logic [BLOCK-1:0] s0,
    output logic [BLOCK-1:0] s1,
    output logic             g,
    output logic             p
);
    logic [BLOCK-1:0] bit_g;
    logic [BLOCK-1:0] bit_p;
    logic [BLOCK:0]   c_gen;
    logic [BLOCK:0]   p_all;
    logic             term;

    // Flat sum-of-products carries: c_gen assumes cin=0, p_all is the cin=1 path.
    always_comb begin
        bit_g = a & b;
        bit_p = a ^ b;
        c_gen = '0;
        p_all = '0;
        term  = 1'b0;
        p_all[0] = 1'b1;
        for (int i = 1; i <= int'(BLOCK); i++) begin
            p_all[i] = 1'b1;
            for (int k = 0; k < i; k++) begin
                p_all[i] = p_all[i] & bit_p[k];
            end
            for (int j = 0; j < i; j++) begin
                term = bit_g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & bit_p[k];
                end
                c_gen[i] = c_gen[i] | term;
            end
        end
    end

    assign s0 = bit_p ^ c_gen[BLOCK-1:0];
    assign s1 = bit_p ^ (c_gen[BLOCK-1:0] | p_all[BLOCK-1:0]);
    assign g  = c_gen[BLOCK];
    assign p  = p_all[BLOCK];
endmodule

// File: rtl/pipelined_cla_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
module pipelined_cla_addsub
    import pipelined_cla_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    pipelined_cla_addsub_if.slave bus
);
    localparam int unsigned NBLK = WIDTH / BLOCK;

    generate
        if ((WIDTH % BLOCK) != 0 || BLOCK < MIN_BLOCK || BLOCK > MAX_BLOCK || WIDTH > MAX_WIDTH)
        begin : g_bad_params
            $error("pipelined_cla_addsub: illegal WIDTH/BLOCK combination");
        end
    endgenerate

    logic [WIDTH-1:0] bb;
    logic             c0;
    logic [WIDTH-1:0] blk_s0;
    logic [WIDTH-1:0] blk_s1;
    logic [NBLK-1:0]  blk_g;
    logic [NBLK-1:0]  blk_p;

    assign bb = bus.b ^ {WIDTH{bus.sub}};
    assign c0 = bus.cin ^ bus.sub;

    for (genvar k = 0; k < int'(NBLK); k++) begin : g_blk
        cla_block_n #(.BLOCK(BLOCK)) u_blk (
            .a  (bus.a[k*BLOCK +: BLOCK]),
            .b  (bb[k*BLOCK +: BLOCK]),
            .s0 (blk_s0[k*BLOCK +: BLOCK]),
            .s1 (blk_s1[k*BLOCK +: BLOCK]),
            .g  (blk_g[k]),
            .p  (blk_p[k])
        );
    end

    logic [WIDTH-1:0] sum0_q, sum0_d, sum1_q, sum1_d;
    logic [NBLK-1:0]  g_q, g_d, p_q, p_d;
    logic             c0_q, c0_d, amsb_q, amsb_d, bbmsb_q, bbmsb_d, s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             out_valid_q, out_valid_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [NBLK:0]    blk_c;
    logic [WIDTH-1:0] sum_sel;
    logic             term;
    logic             in_ready_c, accept_c, advance_c;

    // Inter-block carries as a flat two-level lookahead over registered G/P.
    always_comb begin
        blk_c   = '0;
        sum_sel = '0;
        term    = 1'b0;
        for (int k = 0; k <= int'(NBLK); k++) begin
            term = c0_q;
            for (int j = 0; j < k; j++) begin
                term = term & p_q[j];
            end
            blk_c[k] = term;
            for (int j = 0; j < k; j++) begin
                term = g_q[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & p_q[m];
                end
                blk_c[k] = blk_c[k] | term;
            end
        end
        for (int k = 0; k < int'(NBLK); k++) begin
            sum_sel[k*BLOCK +: BLOCK] = blk_c[k] ? sum1_q[k*BLOCK +: BLOCK]
                                                 : sum0_q[k*BLOCK +: BLOCK];
        end
    end

    always_comb begin
        sum0_d      = sum0_q;
        sum1_d      = sum1_q;
        g_d         = g_q;
        p_d         = p_q;
        c0_d        = c0_q;
        amsb_d      = amsb_q;
        bbmsb_d     = bbmsb_q;
        s1_valid_d  = s1_valid_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;

        in_ready_c = !s1_valid_q || !out_valid_q || bus.out_ready;
        accept_c   = bus.in_valid && in_ready_c;
        advance_c  = s1_valid_q && (!out_valid_q || bus.out_ready);

        if (accept_c) begin
            sum0_d     = blk_s0;
            sum1_d     = blk_s1;
            g_d        = blk_g;
            p_d        = blk_p;
            c0_d       = c0;
            amsb_d     = bus.a[WIDTH-1];
            bbmsb_d    = bb[WIDTH-1];
            s1_valid_d = 1'b1;
        end else if (advance_c) begin
            s1_valid_d = 1'b0;
        end

        // Output handshake and refill share the same edge, so no bubble.
        if (advance_c) begin
            sum_d       = sum_sel;
            cout_d      = blk_c[NBLK];
            ovf_d       = (amsb_q == bbmsb_q) && (sum_sel[WIDTH-1] != amsb_q);
            zero_d      = ~|sum_sel;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sum0_q      <= '0;
            sum1_q      <= '0;
            g_q         <= '0;
            p_q         <= '0;
            c0_q        <= 1'b0;
            amsb_q      <= 1'b0;
            bbmsb_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            sum0_q      <= sum0_d;
            sum1_q      <= sum1_d;
            g_q         <= g_d;
            p_q         <= p_d;
            c0_q        <= c0_d;
            amsb_q      <= amsb_d;
            bbmsb_q     <= bbmsb_d;
            s1_valid_q  <= s1_valid_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed and randomized checks for the pipelined CLA adder/subtractor (32/8 and 16/4 instances).
module tb_pipelined_cla_addsub;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } r32_t;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } r16_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        r32_t        exp;
    } vec32_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        r16_t        exp;
    } vec16_t;

    logic clock;
    logic rst32;
    logic rst16;

    pipelined_cla_addsub_if #(.WIDTH(32)) b32 ();
    pipelined_cla_addsub_if #(.WIDTH(16)) b16 ();

    pipelined_cla_addsub #(.WIDTH(32), .BLOCK(8)) dut32 (.clock(clock), .reset(rst32), .bus(b32));
    pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4)) dut16 (.clock(clock), .reset(rst16), .bus(b16));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_del32 = 0;
    r32_t q32[$];
    r16_t q16[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain wide addition of effective operands.
    function automatic r32_t model32(input logic [31:0] a, input logic [31:0] b,
                                     input logic s, input logic c);
        logic [31:0] bb;
        logic [32:0] t;
        r32_t        r;
        bb     = s ? ~b : b;
        t      = {1'b0, a} + {1'b0, bb} + 33'(c ^ s);
        r.sum  = t[31:0];
        r.cout = t[32];
        r.ovf  = (a[31] == bb[31]) && (t[31] != a[31]);
        r.zero = (t[31:0] == 32'h0);
        return r;
    endfunction

    // One cycle: drive, note acceptance and delivery, advance to just after the edge.
    task automatic step32(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic c, input logic ordy, input r32_t req,
                          output logic acc, output logic ir);
        r32_t got;
        b32.in_valid  = v;
        b32.a         = a;
        b32.b         = b;
        b32.sub       = s;
        b32.cin       = c;
        b32.out_ready = ordy;
        #1;
        ir  = b32.in_ready;
        acc = v && ir;
        if (acc) q32.push_back(req);
        if (b32.out_valid && ordy) begin
            n_del32++;
            chk("pending32", 64'(q32.size() != 0), 64'(1));
            if (q32.size() != 0) begin
                got = '{b32.sum, b32.cout, b32.ovf, b32.zero};
                chk("res32", 64'(got), 64'(q32.pop_front()));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic step16(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c, input logic ordy, input r16_t req,
                          output logic acc);
        r16_t got;
        b16.in_valid  = v;
        b16.a         = a;
        b16.b         = b;
        b16.sub       = s;
        b16.cin       = c;
        b16.out_ready = ordy;
        #1;
        acc = v && b16.in_ready;
        if (acc) q16.push_back(req);
        if (b16.out_valid && ordy) begin
            chk("pending16", 64'(q16.size() != 0), 64'(1));
            if (q16.size() != 0) begin
                got = '{b16.sum, b16.cout, b16.ovf, b16.zero};
                chk("res16", 64'(got), 64'(q16.pop_front()));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain32();
        logic acc, ir;
        for (int i = 0; i < 10 && (q32.size() != 0 || b32.out_valid); i++)
            step32(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, acc, ir);
        chk("drain32", 64'(q32.size()), 64'(0));
    endtask

    task automatic drain16();
        logic acc;
        for (int i = 0; i < 10 && (q16.size() != 0 || b16.out_valid); i++)
            step16(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, acc);
        chk("drain16", 64'(q16.size()), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec32_t      v32[10];
        vec16_t      v16[3];
        logic        acc, ir;
        logic [31:0] ra, rb;
        logic        rc, ordy, vld;
        int          acc_n, k, d;

        v32[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0}};
        v32[1] = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
        v32[2] = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}};
        v32[3] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
        v32[4] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, '{32'h23456789, 1'b0, 1'b0, 1'b0}};
        v32[5] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
        v32[6] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, '{32'h00000006, 1'b1, 1'b0, 1'b0}};
        v32[7] = '{32'h000000FF, 32'h00000000, 1'b0, 1'b1, '{32'h00000100, 1'b0, 1'b0, 1'b0}};
        v32[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b1}};
        v32[9] = '{32'h00FFFF00, 32'h00000100, 1'b0, 1'b0, '{32'h01000000, 1'b0, 1'b0, 1'b0}};

        v16[0] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b1}};
        v16[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0}};
        v16[2] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1}};

        // Reset held two cycles with operands offered.
        rst32 = 1'b1;
        rst16 = 1'b1;
        b32.in_valid = 1'b1; b32.a = 32'h1234; b32.b = 32'h5678; b32.sub = 1'b0;
        b32.cin = 1'b1; b32.out_ready = 1'b1;
        b16.in_valid = 1'b1; b16.a = 16'h1234; b16.b = 16'h5678; b16.sub = 1'b0;
        b16.cin = 1'b1; b16.out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_state32", 64'({b32.out_valid, b32.sum, b32.cout, b32.ovf, b32.zero}), 64'(0));
        chk("rst_state16", 64'({b16.out_valid, b16.sum, b16.cout, b16.ovf, b16.zero}), 64'(0));

        // First operation after release: out_valid rises in cycle 2.
        rst32 = 1'b0;
        rst16 = 1'b0;
        b16.in_valid = 1'b0;
        b32.a = 32'd3; b32.b = 32'd4; b32.cin = 1'b0;
        #1;
        chk("in_ready_release", 64'(b32.in_ready), 64'(1));
        @(posedge clock);
        #1;
        b32.in_valid = 1'b0;
        chk("latency_c1", 64'(b32.out_valid), 64'(0));
        @(posedge clock);
        #1;
        chk("latency_c2", 64'({b32.out_valid, b32.sum}), 64'({1'b1, 32'd7}));
        @(posedge clock);
        #1;

        foreach (v32[i]) begin
            step32(1'b1, v32[i].a, v32[i].b, v32[i].sub, v32[i].cin, 1'b1, v32[i].exp, acc, ir);
            chk("accept_vec32", 64'(acc), 64'(1));
        end
        drain32();

        // Randomized back-pressure against the reference model, add then subtract.
        for (int mode = 0; mode < 2; mode++) begin
            acc_n = 0;
            for (int it = 0; it < 40000 && acc_n < 10000; it++) begin
                ra = $urandom;
                case ($urandom_range(0, 3))
                    0:       rb = ~ra;
                    1:       rb = ra;
                    default: rb = $urandom;
                endcase
                rc   = 1'($urandom_range(0, 1));
                ordy = ($urandom_range(0, 4) != 0);
                vld  = ($urandom_range(0, 7) != 0);
                step32(vld, ra, rb, 1'(mode), rc, ordy, model32(ra, rb, 1'(mode), rc), acc, ir);
                if (acc) acc_n++;
            end
            chk("random_count", 64'(acc_n), 64'(10000));
            drain32();
        end

        // Stall: consumer blocks for 3 cycles while ops 1..4 are offered.
        k = 1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            if (cyc == 2 || cyc == 3)
                chk("stall_hold", 64'({b32.out_valid, b32.sum}), 64'({1'b1, 32'd1}));
            d = n_del32;
            step32(k <= 4, 32'(k), 32'h0, 1'b0, 1'b0, cyc >= 3,
                   '{32'(k), 1'b0, 1'b0, 1'b0}, acc, ir);
            if (cyc == 2) chk("stall_in_ready", 64'(ir), 64'(0));
            if (cyc >= 3 && cyc <= 6) chk("stall_delivery", 64'(n_del32 - d), 64'(1));
            if (acc) k++;
        end
        chk("stall_all_issued", 64'(k), 64'(5));
        drain32();

        foreach (v16[i]) begin
            step16(1'b1, v16[i].a, v16[i].b, v16[i].sub, v16[i].cin, 1'b1, v16[i].exp, acc);
            chk("accept_vec16", 64'(acc), 64'(1));
        end
        drain16();

        // Reset with two operations in flight discards both.
        step16(1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0, 1'b0, '{16'h0033, 1'b0, 1'b0, 1'b0}, acc);
        step16(1'b1, 16'h0044, 16'h0055, 1'b0, 1'b0, 1'b0, '{16'h0099, 1'b0, 1'b0, 1'b0}, acc);
        chk("midrst_pending", 64'(b16.out_valid), 64'(1));
        rst16 = 1'b1;
        b16.in_valid = 1'b0;
        @(posedge clock);
        #1;
        rst16 = 1'b0;
        q16.delete();
        chk("midrst_out_valid", 64'(b16.out_valid), 64'(0));
        chk("midrst_flags", 64'({b16.sum, b16.cout, b16.ovf, b16.zero}), 64'(0));
        b16.out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_s1_empty", 64'(b16.out_valid), 64'(0));
        step16(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, '{16'h0002, 1'b0, 1'b0, 1'b0}, acc);
        drain16();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
